// File: rtl/nios2_ram_arbiter_if.sv
// nios2_ram_arbiter_if: one Avalon-MM style master port into the NIOS2 RAM arbiter
interface nios2_ram_arbiter_if;
    logic [11:0] address;
    logic [3:0]  byteenable;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid;
    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );
    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/nios2_ram_arbiter.sv
// nios2_ram_arbiter: two-master arbiter for the 3072x32 NIOS2 RAM with out-of-range blocking; define NIOS2_RAM_ARB_RR_EN for round-robin, else port 0 has fixed priority
module nios2_ram_arbiter #(
    parameter int DEPTH = 3072,
    parameter int ERR_W = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    nios2_ram_arbiter_if.slave  m0,
    nios2_ram_arbiter_if.slave  m1,
    output logic [11:0]         ram_address,
    output logic [3:0]          ram_byteenable,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [31:0]         ram_writedata,
    output logic                ram_clken,
    input  logic [31:0]         ram_readdata,
    input  logic                err_clr,
    output logic                err_flag,
    output logic [ERR_W-1:0]    err_count
);
    localparam logic [12:0]      LIMIT   = 13'(DEPTH);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    logic       req0, req1, gnt0, gnt1, wr, oor, rd_oor;
    logic [1:0] rd_pend;
`ifdef NIOS2_RAM_ARB_RR_EN
    logic       last;
`endif
    // pick a winner, route it to the RAM and return pipelined read data
    always_comb begin
        req0 = m0.read | m0.write;
        req1 = m1.read | m1.write;
`ifdef NIOS2_RAM_ARB_RR_EN
        gnt0 = reset_n & req0 & (~req1 | last);
`else
        gnt0 = reset_n & req0;
`endif
        gnt1 = reset_n & req1 & ~gnt0;
        ram_address = gnt1 ? m1.address : m0.address;
        ram_byteenable = gnt1 ? m1.byteenable : m0.byteenable;
        ram_writedata = gnt1 ? m1.writedata : m0.writedata;
        wr = gnt1 ? m1.write : m0.write;
        ram_chipselect = gnt0 | gnt1;
        oor = ram_chipselect & ({1'b0, ram_address} >= LIMIT);
        ram_write = ram_chipselect & wr & ~oor;
        ram_clken = reset_n;
        m0.waitrequest = ~reset_n | (req0 & ~gnt0);
        m1.waitrequest = ~reset_n | (req1 & ~gnt1);
        m0.readdatavalid = rd_pend[0];
        m1.readdatavalid = rd_pend[1];
        m0.readdata = (rd_pend[0] & ~rd_oor) ? ram_readdata : '0;
        m1.readdata = (rd_pend[1] & ~rd_oor) ? ram_readdata : '0;
    end
    // remember which port gets read data next cycle; a write with read also asserted returns nothing
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend <= '0;
            rd_oor  <= 1'b0;
        end else begin
            rd_pend <= {gnt1 & ~m1.write, gnt0 & ~m0.write};
            rd_oor  <= oor;
        end
    end
`ifdef NIOS2_RAM_ARB_RR_EN
    // last granted port loses the next contention
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            last <= 1'b1;
        else if (ram_chipselect)
            last <= gnt1;
    end
`endif
    // sticky out-of-range flag and saturating count; a clear coinciding with an error leaves one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_flag  <= 1'b0;
            err_count <= '0;
        end else if (err_clr) begin
            err_flag  <= oor;
            err_count <= {{(ERR_W-1){1'b0}}, oor};
        end else if (oor) begin
            err_flag  <= 1'b1;
            err_count <= err_count + {{(ERR_W-1){1'b0}}, err_count != ERR_MAX};
        end
    end
endmodule

// File: tb/tb_nios2_ram_arbiter.sv
// tb_nios2_ram_arbiter: directed and random checks of the RAM arbiter against a transaction-level model
module tb_nios2_ram_arbiter;
    localparam int DEPTH = 3072;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect, ram_write, ram_clken;
    logic [31:0] ram_writedata;
    logic [31:0] ram_readdata = '0;
    logic        err_clr = 1'b0;
    logic        err_flag;
    logic [7:0]  err_count;

    nios2_ram_arbiter_if m0_if ();
    nios2_ram_arbiter_if m1_if ();

    nios2_ram_arbiter #(.DEPTH(DEPTH), .ERR_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .m0(m0_if), .m1(m1_if),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable),
        .ram_chipselect(ram_chipselect), .ram_write(ram_write),
        .ram_writedata(ram_writedata), .ram_clken(ram_clken),
        .ram_readdata(ram_readdata), .err_clr(err_clr),
        .err_flag(err_flag), .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lanes(logic [3:0] b);
        return {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    endfunction

    // single-port RAM with registered output, old data on read-during-write
    logic [31:0] ram [0:4095] = '{default: 32'h0};
    always @(posedge clk) begin
        if (ram_clken && ram_chipselect) begin
            if (ram_write)
                ram[ram_address] <= (ram[ram_address] & ~lanes(ram_byteenable)) | (ram_writedata & lanes(ram_byteenable));
            ram_readdata <= ram[ram_address];
        end
    end

    // reference model state
    logic [31:0] ref_mem [0:4095] = '{default: 32'h0};
    int          checks = 0, failures = 0;
    int          m_last = 1, e_cnt = 0;
    bit          e_flag = 0;
    bit          rd [2], wr [2], deny [2];
    logic [11:0] ad [2];
    logic [3:0]  be [2];
    logic [31:0] wd [2];
    logic        obs_wt [2], obs_v [2];
    logic [31:0] obs_d [2];
    int          k;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic req(int p, bit r, bit w, logic [11:0] a, logic [3:0] b, logic [31:0] d);
        rd[p] = r; wr[p] = w; ad[p] = a; be[p] = b; wd[p] = d;
    endtask

    task automatic idle();
        req(0, 0, 0, '0, '0, '0);
        req(1, 0, 0, '0, '0, '0);
    endtask

    task automatic apply();
        m0_if.read = rd[0]; m0_if.write = wr[0]; m0_if.address = ad[0];
        m0_if.byteenable = be[0]; m0_if.writedata = wd[0];
        m1_if.read = rd[1]; m1_if.write = wr[1]; m1_if.address = ad[1];
        m1_if.byteenable = be[1]; m1_if.writedata = wd[1];
    endtask

    // one bus cycle: called just after a falling edge with requests prepared
    task automatic step();
        bit          r [2];
        bit          ev [2];
        logic [31:0] ed [2];
        int          w;
        bit          oor;
        apply();
        #1;
        r[0] = rd[0] | wr[0];
        r[1] = rd[1] | wr[1];
        ev[0] = 0; ev[1] = 0; ed[0] = '0; ed[1] = '0; oor = 0;
        w = -1;
        if (r[0] && r[1]) begin
`ifdef NIOS2_RAM_ARB_RR_EN
            w = (m_last == 0) ? 1 : 0;
`else
            w = 0;
`endif
        end else if (r[0]) w = 0;
        else if (r[1]) w = 1;
        check("m0_waitrequest", m0_if.waitrequest, r[0] && w != 0);
        check("m1_waitrequest", m1_if.waitrequest, r[1] && w != 1);
        check("ram_chipselect", ram_chipselect, w >= 0);
        check("ram_clken", ram_clken, 1);
        obs_wt[0] = m0_if.waitrequest;
        obs_wt[1] = m1_if.waitrequest;
        deny[0] = r[0] && w != 0;
        deny[1] = r[1] && w != 1;
        if (w >= 0) begin
            oor = int'(ad[w]) >= DEPTH;
            check("ram_address", ram_address, ad[w]);
            check("ram_write", ram_write, wr[w] && !oor);
            if (wr[w] && !oor) begin
                check("ram_writedata", ram_writedata, wd[w]);
                check("ram_byteenable", ram_byteenable, be[w]);
                ref_mem[ad[w]] = (ref_mem[ad[w]] & ~lanes(be[w])) | (wd[w] & lanes(be[w]));
            end else if (!wr[w]) begin
                ev[w] = 1;
                ed[w] = oor ? 32'h0 : ref_mem[ad[w]];
            end
            m_last = w;
        end else
            check("ram_write_idle", ram_write, 0);
        if (err_clr) begin
            e_cnt = oor ? 1 : 0;
            e_flag = oor;
        end else if (oor) begin
            e_flag = 1;
            if (e_cnt < 255) e_cnt++;
        end
        @(posedge clk);
        #1;
        check("m0_readdatavalid", m0_if.readdatavalid, ev[0]);
        check("m1_readdatavalid", m1_if.readdatavalid, ev[1]);
        check("m0_readdata", m0_if.readdata, ed[0]);
        check("m1_readdata", m1_if.readdata, ed[1]);
        obs_v[0] = m0_if.readdatavalid; obs_d[0] = m0_if.readdata;
        obs_v[1] = m1_if.readdatavalid; obs_d[1] = m1_if.readdata;
        check("err_flag", err_flag, e_flag);
        check("err_count", 32'(err_count), e_cnt);
    endtask

    initial begin
        // reset with requests pending: nothing may be accepted
        req(0, 1, 0, 12'h005, 4'hF, '0);
        req(1, 0, 1, 12'h010, 4'hF, 32'hDEADBEEF);
        apply();
        @(negedge clk);
        #1;
        check("rst_m0_waitrequest", m0_if.waitrequest, 1);
        check("rst_m1_waitrequest", m1_if.waitrequest, 1);
        check("rst_chipselect", ram_chipselect, 0);
        check("rst_ram_write", ram_write, 0);
        check("rst_clken", ram_clken, 0);
        check("rst_m0_readdatavalid", m0_if.readdatavalid, 0);
        check("rst_m0_readdata", m0_if.readdata, 0);
        check("rst_err_flag", err_flag, 0);
        check("rst_err_count", 32'(err_count), 0);
        @(negedge clk);
        reset_n = 1'b1;
        idle();
        step();

        // preload and single read
        @(negedge clk); idle(); req(0, 0, 1, 12'h005, 4'hF, 32'h12345678); step();
        @(negedge clk); idle(); req(0, 1, 0, 12'h005, 4'hF, '0); step();
        check("single_read_data", obs_d[0], 32'h12345678);
        check("single_read_m1_valid", obs_v[1], 0);

        // byte-lane write by m1, leaves port 1 as last granted
        @(negedge clk); idle(); req(1, 0, 1, 12'h010, 4'b0101, 32'hAABBCCDD); step();

        // contention: both read every cycle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req(0, 1, 0, 12'h005, 4'hF, '0);
            req(1, 1, 0, 12'h010, 4'hF, '0);
            step();
`ifdef NIOS2_RAM_ARB_RR_EN
            check("contend_m0_wait", obs_wt[0], i % 2);
            check("contend_m1_wait", obs_wt[1], 1 - i % 2);
`else
            check("contend_m0_wait", obs_wt[0], 0);
            check("contend_m1_wait", obs_wt[1], 1);
`endif
        end
        @(negedge clk); idle(); req(0, 1, 0, 12'h010, 4'hF, '0); step();
        check("byte_write_readback", obs_d[0], 32'h00BB00DD);

        // out-of-range write and read
        @(negedge clk); idle(); req(0, 0, 1, 12'hC00, 4'hF, 32'h55555555); step();
        @(negedge clk); idle(); req(0, 1, 0, 12'hFFF, 4'hF, '0); step();
        check("oor_read_valid", obs_v[0], 1);
        check("oor_read_data", obs_d[0], 0);
        check("oor_err_flag", err_flag, 1);
        check("oor_err_count", 32'(err_count), 2);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); idle();
            req(0, i % 2 == 0, i % 2 == 1, 12'(DEPTH + $urandom_range(0, 1023)), 4'hF, $urandom);
            step();
        end
        check("oor_saturate", 32'(err_count), 255);
        @(negedge clk); idle(); err_clr = 1'b1; step();
        check("err_clr_count", 32'(err_count), 0);
        check("err_clr_flag", err_flag, 0);
        @(negedge clk); idle(); req(1, 1, 0, 12'hD00, 4'hF, '0); step();
        check("clr_with_err_count", 32'(err_count), 1);
        check("clr_with_err_flag", err_flag, 1);
        @(negedge clk); idle(); step();
        err_clr = 1'b0;

        // back-to-back read / write / read on one word
        @(negedge clk); idle(); req(0, 1, 0, 12'h020, 4'hF, '0); step();
        check("b2b_first_read", obs_d[0], 32'h0);
        @(negedge clk); idle(); req(1, 0, 1, 12'h020, 4'hF, 32'hCAFEF00D); step();
        @(negedge clk); idle(); req(0, 1, 0, 12'h020, 4'hF, '0); step();
        check("b2b_second_read", obs_d[0], 32'hCAFEF00D);

        // reset while a read return is outstanding
        @(negedge clk); idle(); req(0, 1, 0, 12'h005, 4'hF, '0); apply();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_m0_readdatavalid", m0_if.readdatavalid, 0);
        check("midrst_m0_readdata", m0_if.readdata, 0);
        check("midrst_m0_waitrequest", m0_if.waitrequest, 1);
        check("midrst_m1_waitrequest", m1_if.waitrequest, 1);
        check("midrst_chipselect", ram_chipselect, 0);
        check("midrst_clken", ram_clken, 0);
        check("midrst_err_count", 32'(err_count), 0);
        idle(); apply();
        m_last = 1; e_cnt = 0; e_flag = 0; deny[0] = 0; deny[1] = 0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_m0_readdatavalid", m0_if.readdatavalid, 0);
        check("postrst_m1_readdatavalid", m1_if.readdatavalid, 0);

        // random traffic; a denied master holds its request
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (!deny[p]) begin
                    k = $urandom_range(0, 3);
                    req(p, k == 1 || k == 3, k >= 2,
                        ($urandom_range(0, 9) == 0) ? 12'(DEPTH + $urandom_range(0, 1023)) : 12'($urandom_range(0, 31)),
                        4'($urandom_range(0, 15)), $urandom);
                end
            end
            err_clr = ($urandom_range(0, 15) == 0);
            step();
        end
        err_clr = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/nios2_ram_arbiter.md
# nios2_ram_arbiter

Two-master arbiter sharing the single-port 3072×32 on-chip NIOS2 RAM (12-bit word address, byte enables, 1-cycle read latency) between the Nios II data master (port 0) and the frequency-measurement capture writer (port 1). Each cycle it grants at most one Avalon-MM style request, drives the RAM port, and returns read data with `readdatavalid`. It also blocks accesses outside the 3072-word range and counts them.

## Interface
Parameters:
- `DEPTH`, 3072: valid words; addresses ≥ DEPTH are out of range.
- `ERR_W`, 8: width of the error counter.

Ports:
- `clk`  in  1  single clock; all logic rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `mN_address`  in  12  word address, N ∈ {0,1}.
- `mN_byteenable`  in  4  byte lanes for writes.
- `mN_read` / `mN_write`  in  1  request strobes.
- `mN_writedata`  in  32  write data.
- `mN_waitrequest`  out  1  1 = request not accepted this cycle.
- `mN_readdata`  out  32  read data, valid only with `mN_readdatavalid`, else 0.
- `mN_readdatavalid`  out  1  one-cycle read-return strobe.
- `ram_address`  out  12;  `ram_byteenable`  out  4;  `ram_chipselect`  out  1;  `ram_write`  out  1;  `ram_writedata`  out  32;  `ram_clken`  out  1: RAM command port.
- `ram_readdata`  in  32  RAM q, valid the cycle after address is presented.
- `err_clr`  in  1  clears `err_flag` and `err_count`.
- `err_flag`  out  1  sticky out-of-range indicator.
- `err_count`  out  ERR_W  saturating out-of-range access count.

## Operation
- Request: `mN_read | mN_write`. Both asserted by one master: treated as a write, no read return.
- Arbitration per cycle among active requesters; winner sees `waitrequest`=0 combinationally in that cycle; loser sees 1 and must hold its request.
- Round-robin: `last` register records the last granted port; if both request, the port ≠ `last` wins. `last` updates on every grant. Reset value `last`=1 (port 0 wins first contention).
- Idle (no request): all `waitrequest`=0, `ram_chipselect`=0.
- RAM drive: winner's address/byteenable/writedata routed; `ram_chipselect`=1; `ram_write`= winner write & in-range; `ram_clken`=1 constantly out of reset, 0 during reset.
- Read pipeline: registered `rd_pend` (one-hot port) and `rd_oor`. Next cycle: `mN_readdatavalid`=1 for pending port; `mN_readdata`=`ram_readdata`, or 0 if `rd_oor`.
- Back-to-back: one accepted transaction per cycle, reads fully pipelined; write immediately after read to the same address returns the old data for the read.
- Out of range (address ≥ DEPTH): accepted (waitrequest 0), write suppressed, read returns 0x00000000 with normal valid timing; `err_flag`←1, `err_count` += 1 saturating at 2^ERR_W−1.
- `err_clr` with simultaneous new error: count=1, flag=1.

## Timing
- Grant latency: 0 cycles when uncontended; ≤1 extra cycle under contention (round-robin).
- Read latency: `readdatavalid` exactly 1 cycle after the accepting edge.
- Reset values: `waitrequest`=1 both ports while `reset_n`=0; `readdatavalid`=0, `readdata`=0, `ram_chipselect`=0, `ram_write`=0, `ram_clken`=0, `err_flag`=0, `err_count`=0, `last`=1.
- Reset mid-read: pending read discarded, no `readdatavalid` after deassertion.

## Configuration
- `NIOS2_RAM_ARB_RR_EN` defined: round-robin as above.
- Undefined: fixed priority, port 0 always wins contention; `last` register absent. All other behaviour identical.

## Test plan
- Single read: m0 reads addr 0x005 (RAM holds 0x12345678) -> m0_waitrequest=0 same cycle, m0_readdatavalid=1 with 0x12345678 next cycle, m1 untouched.
- Contention: both read every cycle for 4 cycles -> grants alternate 0,1,0,1 (RR_EN) / 0,0,0,0 (no macro) with m1 waitrequest held 1.
- Byte write: m1 writes 0xAABBCCDD, byteenable 4'b0101 to 0x010 (old 0x00000000) -> readback 0x00BB00DD.
- Out of range: m0 writes addr 0xC00 then reads 0xFFF -> ram_write=0, read returns 0x00000000, err_flag=1, err_count=2; 300 more such accesses -> err_count=255; err_clr -> 0.
- Reset mid-read: accept m0 read, assert reset_n=0 before next edge -> no readdatavalid, all outputs at reset values.
- Back-to-back: m0 read 0x020, m1 write 0x020, m0 read 0x020 on consecutive cycles -> first read old value, second read new value.
